// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encodings and defaults for uart_word_tx; UART_WORD_TX_PARITY_EN adds the parity state
package uart_pkg;
  localparam int DEF_CLKS_PER_BIT = 5208;
  localparam int DEF_GAP_CLKS = 5;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
`ifdef UART_WORD_TX_PARITY_EN
    B_PARITY,
`endif
    B_STOP,
    B_GAP
  } byte_state_t;
  typedef enum logic [1:0] {W_IDLE, W_LSB, W_MSB} word_state_t;
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: one 8N1 byte (8E1 with UART_WORD_TX_PARITY_EN) plus idle gap, chaining straight into the next byte
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int GAP_CLKS = DEF_GAP_CLKS
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [DATA_BITS-1:0] byte_in,
  input  logic                 byte_start,
  output logic                 byte_done,
  output logic                 line_out
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  byte_state_t state;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic [2:0] bit_idx;
  logic [DATA_BITS-1:0] sh;
  logic bit_last, gap_last;
`ifdef UART_WORD_TX_PARITY_EN
  logic par;
`endif
  assign bit_last = cnt == CW'(CLKS_PER_BIT - 1);
  assign gap_last = gap_cnt == GW'(GAP_CLKS - 1);
  assign byte_done = (GAP_CLKS == 0) ? (state == B_STOP && bit_last) : (state == B_GAP && gap_last);
  // Byte FSM with registered line; a start on the done cycle begins the next start bit with no idle cycle
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state <= B_IDLE;
      cnt <= '0;
      gap_cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      line_out <= 1'b1;
`ifdef UART_WORD_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else if (byte_start && (state == B_IDLE || byte_done)) begin
      state <= B_START;
      cnt <= '0;
      bit_idx <= '0;
      sh <= byte_in;
      line_out <= 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
      par <= ^byte_in;
`endif
    end else if (state != B_IDLE) begin
      cnt <= bit_last ? '0 : cnt + 1'b1;
      case (state)
        B_START: if (bit_last) begin
          state <= B_DATA;
          line_out <= sh[0];
        end
        B_DATA: if (bit_last) begin
          sh <= sh >> 1;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_WORD_TX_PARITY_EN
            state <= B_PARITY;
            line_out <= par;
`else
            state <= B_STOP;
            line_out <= 1'b1;
`endif
          end else line_out <= sh[1];
        end
`ifdef UART_WORD_TX_PARITY_EN
        B_PARITY: if (bit_last) begin
          state <= B_STOP;
          line_out <= 1'b1;
        end
`endif
        B_STOP: if (bit_last) begin
          state <= (GAP_CLKS == 0) ? B_IDLE : B_GAP;
          gap_cnt <= '0;
        end
        B_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_last) state <= B_IDLE;
        end
        default: state <= B_IDLE;
      endcase
    end
endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: sends 16-bit words as two UART bytes, LSB byte first; UART_WORD_TX_PARITY_EN enables even parity
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int GAP_CLKS = DEF_GAP_CLKS
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] tx_word,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        uart_tx_pin,
  output logic        tx_busy,
  output logic [15:0] words_sent
);
  word_state_t w_state;
  logic [15:0] shadow;
  logic start_p, accept, byte_done, byte_start;
  logic [DATA_BITS-1:0] byte_in;
  assign tx_ready = w_state == W_IDLE;
  assign accept = tx_valid && tx_ready;
  assign byte_start = start_p || (w_state == W_LSB && byte_done);
  assign byte_in = byte_done ? shadow[15:8] : shadow[7:0];
  // Word FSM: latch on handshake, hand LSB then MSB to the byte engine, count completed words
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      w_state <= W_IDLE;
      shadow <= '0;
      start_p <= 1'b0;
      tx_busy <= 1'b0;
      words_sent <= '0;
    end else begin
      start_p <= accept;
      if (accept) begin
        shadow <= tx_word;
        w_state <= W_LSB;
        tx_busy <= 1'b1;
      end else if (byte_done && w_state == W_LSB) w_state <= W_MSB;
      else if (byte_done && w_state == W_MSB) begin
        w_state <= W_IDLE;
        tx_busy <= 1'b0;
        words_sent <= words_sent + 1'b1;
      end
    end
  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT), .GAP_CLKS(GAP_CLKS)) u_byte (
    .CLK(CLK),
    .RESET(RESET),
    .byte_in(byte_in),
    .byte_start(byte_start),
    .byte_done(byte_done),
    .line_out(uart_tx_pin)
  );
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: scoreboard bench with a serial decoder; builds with or without UART_WORD_TX_PARITY_EN
module tb_uart_word_tx;
  localparam int CPB = 16;
  localparam int GAP = 4;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int WORD_CLKS = 2 * (FRAME * CPB + GAP);
  logic CLK = 1'b0, RESET = 1'b0, tx_valid = 1'b0;
  logic tx_ready, uart_tx_pin, tx_busy;
  logic [15:0] tx_word = '0, words_sent;
  int n_cmp = 0, n_err = 0, n_bytes = 0, n;
  bit dec_en = 1'b1;
  logic [7:0] exp_q[$];
  logic [7:0] dec_b, dec_e;

  uart_word_tx #(.CLKS_PER_BIT(CPB), .GAP_CLKS(GAP)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .tx_word(tx_word),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .uart_tx_pin(uart_tx_pin),
    .tx_busy(tx_busy),
    .words_sent(words_sent)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic send(input logic [15:0] w, input bit hold);
    int k = 0;
    tx_word = w;
    tx_valid = 1'b1;
    while (!tx_ready && k < 4 * WORD_CLKS) begin
      @(negedge CLK);
      k++;
    end
    check("accept_wait", tx_ready, 1'b1);
    @(posedge CLK);
    if (dec_en) begin
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
    end
    @(negedge CLK);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!tx_ready && k < 8 * WORD_CLKS) begin
      @(negedge CLK);
      k++;
    end
    check(tag, tx_ready, 1'b1);
  endtask

  always begin
    @(negedge CLK iff (dec_en && RESET && !uart_tx_pin));
    if (exp_q.size() != 0) dec_e = exp_q.pop_front();
    else dec_e = 'x;
    repeat (CPB / 2) @(negedge CLK);
    check("start_bit", uart_tx_pin, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge CLK);
      dec_b[i] = uart_tx_pin;
    end
    check("byte", dec_b, dec_e);
`ifdef UART_WORD_TX_PARITY_EN
    repeat (CPB) @(negedge CLK);
    check("parity", uart_tx_pin, ^dec_e);
`endif
    repeat (CPB) @(negedge CLK);
    check("stop_bit", uart_tx_pin, 1'b1);
    n_bytes++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_pin", uart_tx_pin, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_cnt", words_sent, 16'h0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_pin", uart_tx_pin, 1'b1);

`ifdef UART_WORD_TX_PARITY_EN
    send(16'h0701, 1'b0);
`else
    send(16'hA55A, 1'b0);
`endif
    @(negedge CLK);
    check("start_lat", uart_tx_pin, 1'b0);
    check("busy_set", tx_busy, 1'b1);
    check("ready_low", tx_ready, 1'b0);
    n = 0;
    while (!tx_ready && n < 4 * WORD_CLKS) begin
      @(negedge CLK);
      n++;
    end
    check("word_clks", n, WORD_CLKS);
    check("busy_clr", tx_busy, 1'b0);
    check("cnt_1", words_sent, 16'd1);

    send(16'h0003, 1'b1);
    send(16'h1234, 1'b1);
    send(16'hFFFF, 1'b0);
    wait_idle("b2b_idle");
    check("cnt_4", words_sent, 16'd4);

    send(16'h1357, 1'b0);
    repeat (20) @(negedge CLK);
    tx_word = 16'hDEAD;
    tx_valid = 1'b1;
    @(negedge CLK);
    tx_valid = 1'b0;
    wait_idle("hold_idle");
    check("cnt_5", words_sent, 16'd5);
    repeat (3 * CPB) @(negedge CLK);
    check("hold_busy", tx_busy, 1'b0);
    check("hold_cnt", words_sent, 16'd5);
    check("hold_pin", uart_tx_pin, 1'b1);

    force dut.words_sent = 16'hFFFF;
    @(negedge CLK);
    release dut.words_sent;
    @(negedge CLK);
    check("wrap_pre", words_sent, 16'hFFFF);
    send(16'h8001, 1'b0);
    wait_idle("wrap_idle");
    check("wrap_cnt", words_sent, 16'h0000);

    dec_en = 1'b0;
    send(16'h0000, 1'b0);
    repeat (3 * CPB) @(negedge CLK);
    check("mid_pin_low", uart_tx_pin, 1'b0);
    RESET = 1'b0;
    #1;
    check("mid_rst_pin", uart_tx_pin, 1'b1);
    check("mid_rst_ready", tx_ready, 1'b1);
    check("mid_rst_busy", tx_busy, 1'b0);
    check("mid_rst_cnt", words_sent, 16'h0);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2 * CPB) @(negedge CLK);
    check("post_rst_pin", uart_tx_pin, 1'b1);
    check("post_rst_busy", tx_busy, 1'b0);

    check("sb_empty", exp_q.size(), 0);
    check("byte_total", n_bytes, 12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
